// File: rtl/mult_share_ctrl.sv
// Round-robin front end that time-shares one fixed-latency sequential multiplier
// between NUM_REQ requesters and returns each product tagged with its requester ID.
module mult_share_ctrl #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MULT_LATENCY = 20,
  parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic                       mult_start,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic [2*WIDTH-1:0]         mult_out,
  output logic                       busy
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(MULT_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    mult_a_q, mult_a_d;
  logic [WIDTH-1:0]    mult_b_q, mult_b_d;
  logic                mult_start_q, mult_start_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [PROD_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;

  logic                grant_found_c;
  logic [ID_W-1:0]     grant_id_c;
  logic                cnt_done_c;
  int unsigned         scan_idx;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_found_c = 1'b0;
    grant_id_c    = '0;
    scan_idx      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_idx = 32'(rr_ptr_q) + off;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_found_c && req_valid[ID_W'(scan_idx)]) begin
        grant_found_c = 1'b1;
        grant_id_c    = ID_W'(scan_idx);
      end
    end
  end

  assign cnt_done_c = (cnt_q == CNT_W'(MULT_LATENCY - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      mult_start_q <= mult_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found_c) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (cnt_done_c) state_d = RESP;
      RESP:    if (rsp_valid_q && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    req_ready    = '0;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    mult_start_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_found_c) begin
          req_ready[grant_id_c] = 1'b1;
          mult_a_d     = req_a[32'(grant_id_c) * WIDTH +: WIDTH];
          mult_b_d     = req_b[32'(grant_id_c) * WIDTH +: WIDTH];
          id_d         = grant_id_c;
          rr_ptr_d     = (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
          mult_start_d = 1'b1;
        end
      end
      START: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_done_c) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = mult_out;
        end
      end
      RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign mult_start = mult_start_q;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: behavioural multiplier, cycle-level reference model
// of the arbiter/latency contract, and a product scoreboard.
module tb_mult_share_ctrl;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned LAT     = 20;
  localparam int unsigned ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_data;
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_a;
  logic [WIDTH-1:0]         mult_b;
  logic [2*WIDTH-1:0]       mult_out;
  logic                     busy;

  always #5 clk = ~clk;

  mult_share_ctrl #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MULT_LATENCY(LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b), .mult_out(mult_out),
    .busy(busy)
  );

  // Requester-side stimulus, one slot per requester
  logic        v_arr   [NUM_REQ];
  logic [31:0] a_arr   [NUM_REQ];
  logic [31:0] b_arr   [NUM_REQ];
  longint      exp_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]             = v_arr[i];
      req_a[i*WIDTH +: WIDTH]  = a_arr[i];
      req_b[i*WIDTH +: WIDTH]  = b_arr[i];
    end
  end

  // Sequential multiplier stand-in: output is junk until LAT cycles after start
  logic [63:0] mm_p = 64'd0;
  int          mm_k = 0;
  always @(posedge clk) begin
    if (mult_start) begin
      mm_p <= 64'(longint'($signed(mult_a)) * longint'($signed(mult_b)));
      mm_k <= 0;
    end else if (mm_k < 100000) begin
      mm_k <= mm_k + 1;
    end
  end
  assign mult_out = (mm_k >= int'(LAT) - 1) ? mm_p : 64'hDEAD_BEEF_0BAD_F00D;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int     id;
    longint prod;
  } sb_t;

  sb_t         sb[$];
  int          seen_ids[$];
  bit          m_busy = 1'b0;
  int          m_k    = 0;
  int          m_rr   = 0;
  logic [31:0] m_a, m_b;

  // Reference model: k counts cycles since the accept cycle (k=0),
  // START at k=1, response visible from k=LAT+2 until the handshake.
  always @(negedge clk) begin : monitor
    logic [NUM_REQ-1:0] exp_ready;
    bit                 found;
    int                 g;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_rr   = 0;
      sb.delete();
    end else begin
      exp_ready = '0;
      found     = 1'b0;
      g         = 0;
      if (!m_busy) begin
        for (int off = 0; off < NUM_REQ; off++) begin
          int idx;
          idx = (m_rr + off) % NUM_REQ;
          if (!found && v_arr[idx]) begin
            found = 1'b1;
            g     = idx;
          end
        end
      end
      if (found) exp_ready[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("mult_start", 64'(mult_start), 64'(m_busy && m_k == 1));
      check("busy", 64'(busy), 64'(m_busy));
      check("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_k >= int'(LAT) + 2));
      if (m_busy && m_k == 1) begin
        check("mult_a", 64'(mult_a), 64'(m_a));
        check("mult_b", 64'(mult_b), 64'(m_b));
      end
      if (m_busy && m_k >= int'(LAT) + 2 && sb.size() > 0) begin
        check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        check("rsp_data", rsp_data, 64'(sb[0].prod));
      end
      if (!m_busy) begin
        if (found) begin
          m_busy = 1'b1;
          m_k    = 1;
          m_rr   = (g + 1) % NUM_REQ;
          m_a    = a_arr[g];
          m_b    = b_arr[g];
          sb.push_back('{g, exp_arr[g]});
        end
      end else if (m_k >= int'(LAT) + 2 && rsp_ready) begin
        m_busy = 1'b0;
        seen_ids.push_back(int'(rsp_id));
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        m_k++;
      end
    end
  end

  // Raise a request and hold it until granted; expected product recorded with it
  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b, input longint p);
    bit got;
    got        = 1'b0;
    a_arr[i]   = a;
    b_arr[i]   = b;
    exp_arr[i] = p;
    v_arr[i]   = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_timeout", 64'(got), 64'd1);
    @(posedge clk);
    #1 v_arr[i] = 1'b0;
  endtask

  function automatic bit any_valid();
    bit r;
    r = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) r |= v_arr[i];
    return r;
  endfunction

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (!m_busy && sb.size() == 0 && !any_valid()) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"},  64'(req_ready),  64'd0);
    check({pfx, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    check({pfx, "_rsp_id"},     64'(rsp_id),     64'd0);
    check({pfx, "_rsp_data"},   rsp_data,        64'd0);
    check({pfx, "_mult_start"}, 64'(mult_start), 64'd0);
    check({pfx, "_mult_a"},     64'(mult_a),     64'd0);
    check({pfx, "_mult_b"},     64'(mult_b),     64'd0);
    check({pfx, "_busy"},       64'(busy),       64'd0);
  endtask

  task automatic check_order(input string tag, input int exp_ids[$]);
    check({tag, "_count"}, 64'(seen_ids.size()), 64'(exp_ids.size()));
    for (int k = 0; k < exp_ids.size(); k++) begin
      if (k < seen_ids.size()) check({tag, "_order"}, 64'(seen_ids[k]), 64'(exp_ids[k]));
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      v_arr[i]   = 1'b0;
      a_arr[i]   = '0;
      b_arr[i]   = '0;
      exp_arr[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operation on requester 0
    seen_ids.delete();
    do_req(0, 32'd553524, 32'd840, 64'sd464960160);
    wait_done("single_done");
    check_order("single", '{0});

    // Signed operations on requester 2
    do_req(2, -32'sd2, -32'sd2, 64'sd4);
    wait_done("signed1_done");
    do_req(2, 32'd553524, -32'sd259, -64'sd143362716);
    wait_done("signed2_done");
    do_req(2, 32'd1348760118, -32'sd1199060305, -64'sd1617244718460915990);
    wait_done("signed3_done");
    do_req(3, 32'd3, -32'sd3, -64'sd9);
    wait_done("rr_wrap_done");

    // All four contend; requester 0 re-requests straight after its grant
    seen_ids.delete();
    fork
      begin
        do_req(0, 32'd1, 32'd1348760118, 64'sd1348760118);
        do_req(0, 32'd7, 32'd6, 64'sd42);
      end
      do_req(1, -32'sd1199060305, 32'd1, -64'sd1199060305);
      do_req(2, 32'd0, 32'd1348760118, 64'sd0);
      do_req(3, -32'sd259, -32'sd259, 64'sd67081);
    join
    wait_done("contend_done");
    check_order("contend", '{0, 1, 2, 3, 0});

    // Response backpressure with another requester waiting
    seen_ids.delete();
    rsp_ready = 1'b0;
    do_req(1, 32'd12345, -32'sd6789, -64'sd83810205);
    fork
      do_req(2, -32'sd100, 32'd100, -64'sd10000);
    join_none
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (rsp_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("bp_rsp_valid_timeout", 64'(seen), 64'd1);
    end
    repeat (10) @(posedge clk);
    #1;
    check("bp_hold_data", rsp_data, 64'(-64'sd83810205));
    check("bp_hold_id", 64'(rsp_id), 64'd1);
    check("bp_hold_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    wait_done("bp_done");
    check_order("bp", '{1, 2});

    // Reset while the multiplier is running
    do_req(1, 32'd77, 32'd88, 64'sd6776);
    begin
      bit reached;
      reached = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        #1;
        if (m_busy && m_k == 7) begin
          reached = 1'b1;
          break;
        end
      end
      check("mid_reset_reach", 64'(reached), 64'd1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    seen_ids.delete();
    fork
      do_req(1, 32'd5, 32'd0, 64'sd0);
      do_req(3, -32'sd1, -32'sd1, 64'sd1);
    join
    wait_done("post_reset_done");
    check_order("post_reset", '{1, 3});

    // Long idle must leave the round-robin pointer where it was
    do_req(0, 32'd2, 32'd3, 64'sd6);
    wait_done("pre_idle_done");
    repeat (50) @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    seen_ids.delete();
    fork
      do_req(0, 32'd9, -32'sd9, -64'sd81);
      do_req(1, -32'sd4, 32'd11, -64'sd44);
    join
    wait_done("post_idle_done");
    check_order("post_idle", '{1, 0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Round-robin scheduler sharing one sequential Radix-4 signed multiplier (ports start/clk/inputA/inputB/out, no done flag) among NUM_REQ requesters.
- Accepts operand pairs over valid/ready, drives the multiplier's start pulse and holds its operands, times completion with a fixed-latency counter, returns the 64-bit product with the requester ID.
- Sits between the requesting datapath units and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand width; product is 2*WIDTH.
- MULT_LATENCY, 20, clk cycles from the cycle after the start pulse until the multiplier output is valid (must be >= 17 for WIDTH=32).
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  packed signed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed signed operand B, same packing as req_a.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts product.
- rsp_id  out  ID_W  requester index owning rsp_data.
- rsp_data  out  2*WIDTH  signed product.
- mult_start  out  1  to multiplier start.
- mult_a  out  WIDTH  to multiplier inputA.
- mult_b  out  WIDTH  to multiplier inputB.
- mult_out  in  2*WIDTH  from multiplier out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, cnt=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, mult_start=0, mult_a=0, mult_b=0, busy=0.
- Reset mid-operation aborts immediately with no response; the multiplier's internal state is ignored and the next operation re-starts it.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE arbitration:
  - grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally, in IDLE only; all other req_ready bits are 0.
  - On acceptance, latch req_a/req_b of grant into mult_a/mult_b, latch the ID, set rr_ptr=(grant+1) mod NUM_REQ, go to START.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- START: mult_start=1 for exactly this one cycle; cnt cleared to 0; go to WAIT.
- WAIT:
  - cnt increments every cycle.
  - When cnt==MULT_LATENCY-1: capture mult_out into rsp_data, latched ID into rsp_id, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid held high; rsp_data and rsp_id are stable until rsp_ready=1.
  - On rsp_valid and rsp_ready both high: rsp_valid=0 next cycle, go to IDLE.
- mult_a/mult_b remain stable from START through the end of RESP; they change only on an IDLE acceptance.
- Throughput:
  - Accept-to-rsp_valid = MULT_LATENCY+2 cycles.
  - With rsp_ready tied high, one op per MULT_LATENCY+3 cycles.
  - No new acceptance while busy; req_ready=0 throughout.
- Requester protocol: a requester must hold req_valid and its operands stable until it sees req_ready. Deasserting early is legal and is simply not granted.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep waiting; fairness is guaranteed by rr_ptr rotation, so no requester waits more than NUM_REQ operations.
- Arithmetic: the controller does no arithmetic. Signed products pass through bit-exact; an all-zero operand still runs the full latency.

Test Plan:
- Single op, requester 0, A=553524, B=840, rsp_ready=1 -> req_ready[0] high 1 cycle, mult_start high exactly 1 cycle, rsp_valid after MULT_LATENCY+2 cycles, rsp_data=464960160, rsp_id=0.
- Signed ops on requester 2: (-2)*(-2) -> 4; 553524*(-259) -> -143362716; 1348760118*(-1199060305) -> -1617244718460915990, all with rsp_id=2.
- All 4 requesters valid simultaneously with distinct operands (e.g. 1*1348760118, -1199060305*1, 0*1348760118, -259*-259) -> grant order 0,1,2,3; products 1348760118, -1199060305, 0, 67081 in that order; then requester 0 re-requests while 1 also waits -> 1 served before 0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id are stable, req_ready stays 0 for all requesters, mult_start stays 0; releasing rsp_ready returns the FSM to IDLE the next cycle.
- Reset mid-WAIT (rst_n low for 1 cycle at cnt=5) -> all outputs go to their reset values asynchronously, no rsp_valid; a subsequent op 5*0 -> rsp_data=0, rsp_id correct, rr_ptr restarted at 0.
- Idle with no req_valid for 50 cycles -> busy=0, mult_start=0, rr_ptr unchanged.
